// File: rtl/fft_pkg.sv
// Shared types and default sizes for the radix-2 DIT FFT controller.
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fft_seq_state_t;

    typedef logic [FFT_LOG2N-1:0] addr_t;
    typedef logic [FFT_LOG2N-2:0] tw_idx_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address and twiddle index from (stage, k); pure combinational,
// also reused by the datapath write-back path.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic [LOG2N-1:0] stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);

    localparam logic [LOG2N-1:0] ONE = LOG2N'(1);
    localparam logic [LOG2N-1:0] TOP = LOG2N'(LOG2N - 1);

    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;

    always_comb begin
        kx     = {1'b0, k};
        half   = ONE << stage;
        pos    = kx & (half - ONE);
        grp    = kx >> stage;
        addr_a = (grp << (stage + ONE)) | pos;
        addr_b = addr_a + half;
        // pos < half <= N/2, so its top bit is always clear
        tw_idx = pos[LOG2N-2:0] << (TOP - stage);
    end

endmodule

// File: rtl/fft_sequencer.sv
// Stage/op sequencer for the in-place radix-2 DIT butterfly datapath,
// with a pipeline drain between stages to avoid read-after-write hazards.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N        = FFT_N,
    parameter int LOG2N    = FFT_LOG2N,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             op_ready,
    output logic             op_valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [LOG2N-1:0] stage,
    output logic             stage_done,
    output logic             busy,
    output logic             done
);

    localparam int KW = LOG2N - 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [KW-1:0]    K_LAST = KW'(N / 2 - 1);
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam logic [DW-1:0]    D_LOAD = DW'(PIPE_LAT - 1);

    fft_seq_state_t   state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    drain_q, drain_d;

    logic [LOG2N-1:0] ag_a;
    logic [LOG2N-1:0] ag_b;
    logic [LOG2N-2:0] ag_tw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        k_d        = k_q;
        drain_d    = drain_q;
        stage_done = 1'b0;
        done       = 1'b0;
        op_valid   = (state_q == ISSUE);

        // abort wins over everything and suppresses both pulses
        if (abort) begin
            state_d = IDLE;
            stage_d = '0;
            k_d     = '0;
            drain_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ISSUE;
                        stage_d = '0;
                        k_d     = '0;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        if (k_q == K_LAST) begin
                            drain_d = D_LOAD;
                            state_d = DRAIN;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        stage_done = 1'b1;
                        k_d        = '0;
                        if (stage_q == S_LAST) begin
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE;
                            stage_d = stage_q + LOG2N'(1);
                        end
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                    stage_d = '0;
                    k_d     = '0;
                end
            endcase
        end
    end

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage  (stage_q),
        .k      (k_q),
        .addr_a (ag_a),
        .addr_b (ag_b),
        .tw_idx (ag_tw)
    );

    assign addr_a = op_valid ? ag_a  : '0;
    assign addr_b = op_valid ? ag_b  : '0;
    assign tw_idx = op_valid ? ag_tw : '0;
    assign stage  = stage_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed and randomised-backpressure bench for fft_sequencer
// (N=8 and N=64 instances).
module tb_fft_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- N=8 instance ----------------
    logic       rst8 = 1'b1, start8 = 1'b0, abort8 = 1'b0, ready8 = 1'b1;
    logic       v8, sd8, busy8, done8;
    logic [2:0] a8, b8, s8;
    logic [1:0] tw8;

    fft_sequencer #(.N(8), .LOG2N(3), .PIPE_LAT(2)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .start      (start8),
        .abort      (abort8),
        .op_ready   (ready8),
        .op_valid   (v8),
        .addr_a     (a8),
        .addr_b     (b8),
        .tw_idx     (tw8),
        .stage      (s8),
        .stage_done (sd8),
        .busy       (busy8),
        .done       (done8)
    );

    int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    bit          mon8 = 1'b0;
    int          t0   = 0;
    int          q_ops[$];
    int          q_sd[$];
    int          q_done[$];
    int          n_hold;
    logic [14:0] zero_log [64];
    bit          busy_log [64];
    bit          valid_log[64];

    always @(negedge clk) begin : mon8_blk
        int rel;
        if (mon8) begin
            rel = cyc - t0;
            if (rel >= 0 && rel < 64) begin
                zero_log[rel]  = {v8, busy8, done8, sd8, a8, b8, tw8, s8};
                busy_log[rel]  = busy8;
                valid_log[rel] = v8;
            end
            if (v8 && ready8) q_ops.push_back(int'({s8, a8, b8, tw8}));
            if (v8 && s8 == 3'd1 && a8 == 3'd1) n_hold++;
            if (sd8) q_sd.push_back(rel);
            if (done8) q_done.push_back(rel);
        end
    end

    task automatic run8(input int ncyc, input int rlo, input int rhi,
                        input int ab_at, input int xs_a, input int xs_b,
                        input int rst_at);
        q_ops.delete();
        q_sd.delete();
        q_done.delete();
        n_hold = 0;
        for (int i = 0; i < 64; i++) begin
            zero_log[i]  = '1;
            busy_log[i]  = 1'b1;
            valid_log[i] = 1'b1;
        end
        t0   = cyc;
        mon8 = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            start8 = (c == 0) || (c == xs_a) || (c == xs_b);
            ready8 = !(c >= rlo && c <= rhi);
            abort8 = (c == ab_at);
            rst8   = (c == rst_at);
            tick();
        end
        start8 = 1'b0;
        ready8 = 1'b1;
        abort8 = 1'b0;
        rst8   = 1'b0;
        mon8   = 1'b0;
    endtask

    task automatic check_ops(input int n);
        for (int i = 0; i < n; i++) begin
            int got;
            int exp;
            got = (i < q_ops.size()) ? q_ops[i] : -1;
            exp = int'({3'(i / 4), 3'(ea[i]), 3'(eb[i]), 2'(et[i])});
            chk($sformatf("op%0d", i), got, exp);
        end
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    // ---------------- N=64 instance ----------------
    logic       rst64 = 1'b1, start64 = 1'b0, abort64 = 1'b0, ready64 = 1'b1;
    logic       v64, sd64, busy64, done64;
    logic [5:0] a64, b64, s64;
    logic [4:0] tw64;

    fft_sequencer dut64 (
        .clk        (clk),
        .rst        (rst64),
        .start      (start64),
        .abort      (abort64),
        .op_ready   (ready64),
        .op_valid   (v64),
        .addr_a     (a64),
        .addr_b     (b64),
        .tw_idx     (tw64),
        .stage      (s64),
        .stage_done (sd64),
        .busy       (busy64),
        .done       (done64)
    );

    bit mon64    = 1'b0;
    int t64      = 0;
    int n64      = 0;
    int stalls   = 0;
    int done_cnt = 0;
    int done_rel = -1;
    bit seen [6][64];

    always @(negedge clk) begin : mon64_blk
        int sv, av, half;
        if (mon64) begin
            if (v64 && !ready64) stalls++;
            if (v64 && ready64) begin
                n64++;
                sv   = int'(s64);
                av   = int'(a64);
                half = 1 << sv;
                chk("b64", b64, av + half);
                chk("top64", (av >> sv) & 1, 0);
                chk("tw64", tw64, (av & (half - 1)) << (5 - sv));
                if (sv < 6) begin
                    chk("dup64", seen[sv][av], 0);
                    seen[sv][av] = 1'b1;
                end
            end
            if (done64) begin
                done_cnt++;
                done_rel = cyc - t64;
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", v8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sdone", sd8, 0);
        chk("rst_addr_a", a8, 0);
        chk("rst_addr_b", b8, 0);
        chk("rst_tw", tw8, 0);
        chk("rst_stage", s8, 0);
        rst8  = 1'b0;
        rst64 = 1'b0;
        tick();

        // plain run
        run8(22, -1, -1, -1, -1, -1, -1);
        chk("nom_nops", q_ops.size(), 12);
        check_ops(12);
        chk("nom_nsd", q_sd.size(), 3);
        chk("nom_sd0", first(q_sd), 6);
        chk("nom_sd1", (q_sd.size() > 1) ? q_sd[1] : -1, 12);
        chk("nom_sd2", (q_sd.size() > 2) ? q_sd[2] : -1, 18);
        chk("nom_ndone", q_done.size(), 1);
        chk("nom_done", first(q_done), 19);
        chk("nom_busy19", busy_log[19], 1);
        chk("nom_busy20", busy_log[20], 0);

        // backpressure on stage 1, k=1
        run8(25, 8, 10, -1, -1, -1, -1);
        chk("bp_nops", q_ops.size(), 12);
        check_ops(12);
        chk("bp_hold", n_hold, 4);
        chk("bp_done", first(q_done), 22);

        // abort in stage-0 drain, then restart
        run8(25, -1, -1, 5, -1, -1, -1);
        chk("ab_busy", busy_log[6], 0);
        chk("ab_valid", valid_log[6], 0);
        chk("ab_nops", q_ops.size(), 4);
        chk("ab_nsd", q_sd.size(), 0);
        chk("ab_ndone", q_done.size(), 0);
        run8(22, -1, -1, -1, -1, -1, -1);
        check_ops(12);
        chk("ab2_done", first(q_done), 19);

        // start while busy and in DONE cycle
        run8(26, -1, -1, -1, 10, 19, -1);
        chk("xs_nops", q_ops.size(), 12);
        chk("xs_ndone", q_done.size(), 1);
        chk("xs_busy21", busy_log[21], 0);

        // start together with abort in IDLE
        run8(4, -1, -1, 0, -1, -1, -1);
        chk("sa_nops", q_ops.size(), 0);
        chk("sa_busy", busy_log[1], 0);
        chk("sa_valid", valid_log[1], 0);

        // reset mid stage 2, then restart
        run8(20, -1, -1, -1, -1, -1, 14);
        chk("mr_zero", zero_log[15], 0);
        chk("mr_ndone", q_done.size(), 0);
        run8(3, -1, -1, -1, -1, -1, -1);
        check_ops(1);

        // N=64 with random backpressure
        t64  = cyc;
        mon64 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            start64 = (c == 0);
            ready64 = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt > 0) break;
        end
        start64 = 1'b0;
        ready64 = 1'b1;
        repeat (6) tick();
        mon64 = 1'b0;
        chk("r_nops", n64, 192);
        chk("r_ndone", done_cnt, 1);
        chk("r_done", done_rel, 205 + stalls);
        for (int s = 0; s < 6; s++) begin
            int cnt;
            cnt = 0;
            for (int a = 0; a < 64; a++) cnt += int'(seen[s][a]);
            chk($sformatf("r_cover%0d", s), cnt, 32);
        end
        chk("r_idle", busy64, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
